// File: rtl/sprite_layer_compositor.sv
// rtl/sprite_layer_compositor.sv - per-pixel sprite priority scan and background qualification
// Scans N_SPRITES register channels one per cycle; the lowest hitting index wins.
module sprite_layer_compositor #(
  parameter int N_SPRITES       = 8,
  parameter int SPRITE_SIZE     = 20,
  parameter int COORD_W         = 10,
  parameter int ADDR_W          = 14,
  parameter int COLOR_W         = 9,
  parameter int INVISIBLE_COLOR = 510,
  localparam int SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COLOR_W-1:0] block_color,
  output logic [SEL_W-1:0]   sprite_sel,
  input  logic [31:0]        sprite_data,
  output logic               busy,
  output logic               out_valid,
  output logic               out_is_sprite,
  output logic [SEL_W-1:0]   out_sprite_idx,
  output logic [ADDR_W-1:0]  memory_address,
  output logic               out_is_block,
  output logic [COLOR_W-1:0] out_block_color
);

  localparam int CMP_W  = ((COORD_W > 10) ? COORD_W : 10) + 1;
  localparam int CALC_W = 32;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic [COLOR_W-1:0] blk_q, blk_d;
  logic               hit_q, hit_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               res_sprite_q, res_sprite_d;
  logic [SEL_W-1:0]   res_idx_q, res_idx_d;
  logic [ADDR_W-1:0]  res_addr_q, res_addr_d;
  logic               res_block_q, res_block_d;
  logic [COLOR_W-1:0] res_color_q, res_color_d;

  logic              spr_active;
  logic [9:0]        spr_x, spr_y;
  logic [8:0]        spr_off;
  logic [CMP_W-1:0]  px_w, py_w, x_w, y_w, size_w, dx, dy;
  logic              in_x, in_y, hit_now, last_ch;
  logic [CALC_W-1:0] addr_calc;
  logic              unused_bits;

  assign spr_active  = sprite_data[31];
  assign spr_x       = sprite_data[28:19];
  assign spr_y       = sprite_data[18:9];
  assign spr_off     = sprite_data[8:0];
  assign unused_bits = ^sprite_data[30:29];

  // One extra bit keeps x+SPRITE_SIZE from wrapping back to column 0.
  assign px_w    = CMP_W'(px_q);
  assign py_w    = CMP_W'(py_q);
  assign x_w     = CMP_W'(spr_x);
  assign y_w     = CMP_W'(spr_y);
  assign size_w  = CMP_W'(SPRITE_SIZE);
  assign in_x    = (px_w >= x_w) && (px_w < x_w + size_w);
  assign in_y    = (py_w >= y_w) && (py_w < y_w + size_w);
  assign hit_now = spr_active && in_x && in_y;
  assign dx      = px_w - x_w;
  assign dy      = py_w - y_w;
  assign last_ch = (sel_q == SEL_W'(N_SPRITES - 1));

  assign addr_calc = CALC_W'(spr_off) * CALC_W'(SPRITE_SIZE * SPRITE_SIZE)
                   + CALC_W'(dy) * CALC_W'(SPRITE_SIZE) + CALC_W'(dx);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    px_d         = px_q;
    py_d         = py_q;
    blk_d        = blk_q;
    hit_d        = hit_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    res_sprite_d = res_sprite_q;
    res_idx_d    = res_idx_q;
    res_addr_d   = res_addr_q;
    res_block_d  = res_block_q;
    res_color_d  = res_color_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          px_d    = pixel_x;
          py_d    = pixel_y;
          blk_d   = block_color;
          hit_d   = 1'b0;
          idx_d   = '0;
          addr_d  = '0;
          sel_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_now && !hit_q) begin
          hit_d  = 1'b1;
          idx_d  = sel_q;
          addr_d = ADDR_W'(addr_calc);
        end
        // Results load on the way into DONE so they are visible with out_valid.
        if (last_ch) begin
          state_d      = DONE;
          sel_d        = '0;
          res_sprite_d = hit_d;
          res_idx_d    = idx_d;
          res_addr_d   = addr_d;
          res_block_d  = (blk_q != COLOR_W'(INVISIBLE_COLOR));
          res_color_d  = blk_q;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      blk_q        <= '0;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      addr_q       <= '0;
      res_sprite_q <= 1'b0;
      res_idx_q    <= '0;
      res_addr_q   <= '0;
      res_block_q  <= 1'b0;
      res_color_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      px_q         <= px_d;
      py_q         <= py_d;
      blk_q        <= blk_d;
      hit_q        <= hit_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      res_sprite_q <= res_sprite_d;
      res_idx_q    <= res_idx_d;
      res_addr_q   <= res_addr_d;
      res_block_q  <= res_block_d;
      res_color_q  <= res_color_d;
    end
  end

  assign sprite_sel      = sel_q;
  assign busy            = (state_q == SCAN);
  assign out_valid       = (state_q == DONE);
  assign out_is_sprite   = res_sprite_q;
  assign out_sprite_idx  = res_idx_q;
  assign memory_address  = res_addr_q;
  assign out_is_block    = res_block_q;
  assign out_block_color = res_color_q;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// tb/tb_sprite_layer_compositor.sv - directed self-checking bench for sprite_layer_compositor
module tb_sprite_layer_compositor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [8:0]  block_color;
  logic [2:0]  sprite_sel;
  logic [31:0] sprite_data;
  logic        busy;
  logic        out_valid;
  logic        out_is_sprite;
  logic [2:0]  out_sprite_idx;
  logic [13:0] memory_address;
  logic        out_is_block;
  logic [8:0]  out_block_color;

  logic [31:0] regs [8];
  int compared;
  int mismatched;

  sprite_layer_compositor dut (
    .clk(clk), .reset(reset), .start(start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .block_color(block_color),
    .sprite_sel(sprite_sel), .sprite_data(sprite_data),
    .busy(busy), .out_valid(out_valid),
    .out_is_sprite(out_is_sprite), .out_sprite_idx(out_sprite_idx),
    .memory_address(memory_address), .out_is_block(out_is_block),
    .out_block_color(out_block_color)
  );

  assign sprite_data = regs[sprite_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] spr(input bit act, input int x, input int y, input int off);
    logic [9:0] xv;
    logic [9:0] yv;
    logic [8:0] ov;
    xv = 10'(x);
    yv = 10'(y);
    ov = 9'(off);
    return {act, 2'b00, xv, yv, ov};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;
  endtask

  // Starts a pixel from IDLE and returns the cycle number of out_valid (40 on timeout).
  task automatic run_pixel(input int x, input int y, input int color, output int lat);
    int cyc;
    @(posedge clk); #1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    block_color = 9'(color);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc;
  endtask

  task automatic check_result(input string tag, input int lat, input int is_spr, input int idx,
                              input int addr, input int is_blk, input int color);
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " is_sprite"}, 32'(out_is_sprite), 32'(is_spr));
    check({tag, " idx"}, 32'(out_sprite_idx), 32'(idx));
    check({tag, " addr"}, 32'(memory_address), 32'(addr));
    check({tag, " is_block"}, 32'(out_is_block), 32'(is_blk));
    check({tag, " color"}, 32'(out_block_color), 32'(color));
  endtask

  initial begin
    int lat;
    int pulses;
    int vcyc;
    logic [13:0] addr_seen;
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    block_color = '0;
    clear_regs();

    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sprite_sel", 32'(sprite_sel), 32'd0);
    check("rst outputs", {out_is_sprite, out_is_block, out_sprite_idx, memory_address, out_block_color}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    check("idle no activity", 32'(pulses), 32'd0);

    regs[3] = spr(1, 100, 50, 2);
    run_pixel(105, 52, 37, lat);
    check_result("basic", lat, 1, 3, 845, 1, 37);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold valid low", 32'(out_valid), 32'd0);
    check("hold addr", 32'(memory_address), 32'd845);

    clear_regs();
    regs[2] = spr(1, 0, 0, 0);
    regs[5] = spr(1, 5, 5, 1);
    run_pixel(10, 10, 5, lat);
    check_result("priority", lat, 1, 2, 210, 1, 5);

    clear_regs();
    regs[3] = spr(1, 100, 50, 2);
    run_pixel(120, 50, 510, lat);
    check_result("right edge", lat, 0, 0, 0, 0, 510);
    run_pixel(119, 50, 7, lat);
    check_result("last column", lat, 1, 3, 819, 1, 7);

    regs[3] = spr(0, 100, 50, 2);
    run_pixel(105, 52, 1, lat);
    check_result("inactive", lat, 0, 0, 0, 1, 1);

    clear_regs();
    regs[0] = spr(1, 1015, 100, 0);
    run_pixel(3, 110, 9, lat);
    check_result("no wrap", lat, 0, 0, 0, 1, 9);
    run_pixel(1020, 110, 9, lat);
    check_result("offscreen hit", lat, 1, 0, 205, 1, 9);

    clear_regs();
    regs[3] = spr(1, 100, 50, 2);
    @(posedge clk); #1;
    pixel_x = 10'd105;
    pixel_y = 10'd52;
    block_color = 9'd37;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    vcyc = 0;
    addr_seen = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 4) begin
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        start = 1'b1;
      end
      if (cyc == 5) start = 1'b0;
      if (out_valid === 1'b1) begin
        pulses++;
        vcyc = cyc;
        addr_seen = memory_address;
      end
      @(posedge clk); #1;
    end
    check("restart pulses", 32'(pulses), 32'd1);
    check("restart cycle", 32'(vcyc), 32'd9);
    check("restart addr", 32'(addr_seen), 32'd845);

    @(posedge clk); #1;
    pixel_x = 10'd105;
    pixel_y = 10'd52;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 5) begin
        reset = 1'b1;
        #1;
      end
      if (cyc == 7) reset = 1'b0;
      if (out_valid === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check("abort no valid", 32'(pulses), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort cleared addr", 32'(memory_address), 32'd0);
    run_pixel(105, 52, 37, lat);
    check_result("after abort", lat, 1, 3, 845, 1, 37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_layer_compositor.md
Name: sprite_layer_compositor

Overview:
- Parametrised successor of the per-pixel drawing stage.
- Time-multiplexes a scan over N_SPRITES sprite registers for one pixel and resolves priority (lowest index wins).
- Computes the winning sprite's memory address and qualifies the background block colour.
- Sits between the VGA pixel sequencer (start/pixel coordinates) and the colour-memory/output mux; presents one result per start with fixed latency.

Parameters:
- N_SPRITES, 8, number of sprite channels scanned per pixel (1..32).
- SPRITE_SIZE, 20, sprite width and height in pixels.
- COORD_W, 10, width of pixel_x/pixel_y.
- ADDR_W, 14, sprite memory address width.
- COLOR_W, 9, background colour width.
- INVISIBLE_COLOR, 510, block colour meaning "block inactive".

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin processing pixel (pixel_x, pixel_y).
- pixel_x  in  COORD_W  pixel column, sampled on accepted start.
- pixel_y  in  COORD_W  pixel row, sampled on accepted start.
- block_color  in  COLOR_W  background block colour, sampled on accepted start.
- sprite_sel  out  clog2(N_SPRITES) (min 1)  index of sprite register currently requested.
- sprite_data  in  32  register contents for sprite_sel, same cycle (combinational register-file read). Fields: [31] active, [28:19] x, [18:9] y, [8:0] offset.
- busy  out  1  high while scanning.
- out_valid  out  1  one-cycle pulse; result outputs updated this cycle.
- out_is_sprite  out  1  a sprite covers the pixel.
- out_sprite_idx  out  clog2(N_SPRITES) (min 1)  winning channel index.
- memory_address  out  ADDR_W  texel address of the winning sprite.
- out_is_block  out  1  block_color != INVISIBLE_COLOR.
- out_block_color  out  COLOR_W  sampled block colour.

Behaviour:
- Reset (async, any state): FSM = IDLE, sprite_sel = 0, busy = 0, out_valid = 0; all result outputs cleared to 0.
- FSM IDLE:
  - On start: latch pixel_x, pixel_y, block_color.
  - Clear the hit flag; set sprite_sel = 0; go to SCAN; busy = 1 from the next cycle.
- FSM SCAN: one channel per cycle.
  - Hit = active && px >= x && px < x+SPRITE_SIZE && py >= y && py < y+SPRITE_SIZE.
  - Comparisons use COORD_W+1 bits, so x+SPRITE_SIZE never wraps.
  - On the first hit only, latch the index and address = offset*SPRITE_SIZE*SPRITE_SIZE + (py-y)*SPRITE_SIZE + (px-x), truncated to ADDR_W bits. Later hits are ignored (lowest index has priority).
  - After channel N_SPRITES-1, go to DONE.
- FSM DONE, one cycle:
  - out_valid = 1; update out_is_sprite, out_sprite_idx, memory_address, out_is_block, out_block_color.
  - busy = 0; return to IDLE.
- Latency: start accepted in cycle 0 -> SCAN occupies cycles 1..N_SPRITES -> out_valid in cycle N_SPRITES+1.
  - Full scan always, even after an early hit, so latency is deterministic.
  - Minimum start-to-start spacing is N_SPRITES+2 cycles.
- No hit: out_is_sprite = 0, out_sprite_idx = 0, memory_address = 0.
- Result outputs hold their values between out_valid pulses.
- start while busy or in DONE: ignored; no queueing, no state change.
- start coinciding with reset: reset wins.
- Reset mid-scan: abort immediately; no out_valid is produced for the aborted pixel.
- N_SPRITES = 1: sprite_sel is constantly 0; latency is 2.
- Sprite partly off-screen (x + SPRITE_SIZE > 2^COORD_W): only on-screen pixels hit; no wrap to column 0.
- Inactive sprite (bit 31 = 0): never hits, regardless of coordinates.

Test Plan:
- Reset then idle with start = 0 -> busy = 0, out_valid never asserted, all outputs 0.
- N=8: sprite 3 {active, x=100, y=50, offset=2}, others inactive; start at (105,52), block_color = 37 -> out_valid exactly at cycle 9; out_is_sprite = 1, idx = 3, memory_address = 800+40+5 = 845, out_is_block = 1, out_block_color = 37.
- Sprites 2 and 5 both cover (10,10), offsets 0 and 1 -> idx = 2, address from sprite 2.
- Pixel (120,50) with sprite at x=100 (right edge is exclusive); block_color = 510 -> out_is_sprite = 0, out_is_block = 0, out_block_color = 510.
- Sprite at x=1015 (COORD_W = 10), pixel (3,y) -> no hit; pixel (1020,y) with y inside -> hit.
- start pulsed again in cycle 4 of a scan -> ignored; a single out_valid at cycle 9. Assert reset in cycle 5 of a fresh scan -> no out_valid; next start completes normally.
